// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_add_sub
// Description : Carry-slice pipelined adder/subtractor with valid/ready flow
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_add_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  // Rank k holds the state leaving stage k; rank STAGES-1 is the output register.
  logic             r_v   [STAGES];
  logic             r_sub [STAGES];
  logic             r_c   [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_ovf;
  logic             w_stall;

  assign out_valid = r_v[STAGES-1];
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;

    logic             w_v;
    logic             w_sub;
    logic             w_c;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_s;
    logic [SLICE-1:0] w_bm;
    logic [SLICE-1:0] w_slice;
    logic             w_co;
    logic [WIDTH-1:0] w_s_nxt;

    if (k == 0) begin : g_head
      // Subtract is a + ~b + ~cin, so the incoming borrow is inverted here once.
      assign w_v   = in_valid;
      assign w_sub = sub;
      assign w_c   = cin ^ sub;
      assign w_a   = a;
      assign w_b   = b;
      assign w_s   = '0;
    end else begin : g_body
      assign w_v   = r_v[k-1];
      assign w_sub = r_sub[k-1];
      assign w_c   = r_c[k-1];
      assign w_a   = r_a[k-1];
      assign w_b   = r_b[k-1];
      assign w_s   = r_s[k-1];
    end

    assign w_bm = w_b[LO +: SLICE] ^ {SLICE{w_sub}};
    assign {w_co, w_slice} = {1'b0, w_a[LO +: SLICE]} + {1'b0, w_bm}
                           + {{SLICE{1'b0}}, w_c};

    always_comb begin
      w_s_nxt              = w_s;
      w_s_nxt[LO +: SLICE] = w_slice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[k]   <= 1'b0;
        r_sub[k] <= 1'b0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
      end else if (!w_stall) begin
        r_v[k]   <= w_v;
        r_sub[k] <= w_sub;
        r_c[k]   <= w_co;
        r_a[k]   <= w_a;
        r_b[k]   <= w_b;
        r_s[k]   <= w_s_nxt;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      // Top slice is processed here, so the sign bits are all visible in this stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (!w_stall) begin
          r_ovf <= (w_a[WIDTH-1] == w_bm[SLICE-1]) && (w_slice[SLICE-1] != w_a[WIDTH-1]);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_add_sub
// Description : Self-checking bench for pipelined_add_sub against an arithmetic model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_add_sub;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         nxt;
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  int           n_out = 0;
  bit           chk_lat = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_cout = 1'b0;
  logic         prev_ovf  = 1'b0;
  bit           acc_f;
  int           idx;
  int           n0;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Plain integer arithmetic: unsigned result for sum/cout, signed range for ovf.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    exp_t   m;
    longint r, sr, sx, sy, ux, uy, c;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c  = ci ? 64'sd1 : 64'sd0;
    if (sb) begin
      r   = ux - uy - c;
      sr  = sx - sy - c;
      m.c = (r >= 0);
    end else begin
      r   = ux + uy + c;
      sr  = sx + sy + c;
      m.c = (r >= (64'sd1 <<< W));
    end
    m.s   = r[W-1:0];
    m.o   = (sr > ((64'sd1 <<< (W-1)) - 1)) || (sr < -(64'sd1 <<< (W-1)));
    m.acc = 0;
    return m;
  endfunction

  task automatic put(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic ci, input logic sb, input bit ordy);
    in_valid  = v;
    a         = x;
    b         = y;
    cin       = ci;
    sub       = sb;
    out_ready = ordy;
    nxt       = model(x, y, ci, sb);
  endtask

  // Entered 1 time unit after a rising edge with inputs already applied.
  task automatic cycle(output bit acc);
    exp_t e;
    #1;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (prev_stall) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_sum", sum, prev_sum);
      check("hold_cout", cout, prev_cout);
      check("hold_ovf", ovf, prev_ovf);
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e.s);
        check("cout", cout, e.c);
        check("ovf", ovf, e.o);
        if (chk_lat) check("latency", cyc - e.acc, S);
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e     = nxt;
      e.acc = cyc;
      exp_q.push_back(e);
    end
    prev_stall = out_valid && !out_ready;
    prev_sum   = sum;
    prev_cout  = cout;
    prev_ovf   = ovf;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [W-1:0] da [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  logic [W-1:0] db [5] = '{16'h4321, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
  logic         dc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic         dsb[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] es [5] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
  logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors with fixed expected results and exact latency.
    chk_lat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(1'b1, da[i], db[i], dc[i], dsb[i], 1'b1);
      nxt.s = es[i];
      nxt.c = ec[i];
      nxt.o = eo[i];
      cycle(acc_f);
    end
    for (int i = 0; i < S + 3; i++) begin
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cycle(acc_f);
    end
    check("directed_drain", exp_q.size(), 0);

    // Back-pressure: six back-to-back operands, output stalled for five cycles.
    chk_lat = 1'b0;
    idx = 0;
    n0  = n_out;
    for (int t = 0; t < 24; t++) begin
      put(idx < 6, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
          !(t >= 5 && t <= 9));
      cycle(acc_f);
      if (acc_f) idx++;
    end
    check("bp_results", n_out - n0, 6);
    check("bp_drain", exp_q.size(), 0);

    // Reset mid-stream with results in flight and one stalled at the output.
    for (int t = 0; t < 6; t++) begin
      put(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      cycle(acc_f);
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_ready", in_ready, 1'b1);
    check("async_rst_sum", sum, '0);
    check("async_rst_cout", cout, 1'b0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = n_out;
    for (int t = 0; t < S + 3; t++) begin
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cycle(acc_f);
    end
    check("no_stale_after_rst", n_out - n0, 0);
    chk_lat = 1'b1;
    put(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    cycle(acc_f);
    for (int t = 0; t < S + 2; t++) begin
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cycle(acc_f);
    end
    check("post_rst_results", n_out - n0, 1);

    // Random traffic with random bubbles and back-pressure.
    chk_lat = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = W'($urandom);
      if ($urandom_range(0, 7) == 0) x = '1;
      if ($urandom_range(0, 7) == 0) y = ($urandom_range(0, 1) == 1) ? '0 : {1'b1, {(W-1){1'b0}}};
      put($urandom_range(0, 9) < 7, x, y, 1'($urandom), 1'($urandom),
          $urandom_range(0, 3) != 0);
      cycle(acc_f);
    end
    for (int t = 0; t < 40 && exp_q.size() > 0; t++) begin
      put(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      cycle(acc_f);
    end
    check("random_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
